mux_serializer: RTL and testbench

- Recombines N parallel lanes into one serial sample stream; inverse of the FFT-stage demux.
- Sits at the output of a stage. Captures one N-lane word per input handshake.
- Emits the lanes one per output handshake, lane 0 first, under valid/ready flow control.
- Gives a stage that fans data out through the demux a way to collapse it back to a single stream.

---
 rtl/mux_serializer.sv | 119 +++++++++++
 tb/tb_mux_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_serializer.sv
// mux_serializer
//   Collapses one N-lane parallel word back into a serial sample stream.
//   A word is captured on each input handshake and its lanes are emitted
//   one per output handshake, lane 0 first. When the final lane leaves in
//   the same cycle that a new word is offered, the new word is captured
//   directly, so back-to-back words run without a bubble.
//
// Parameters
//   MSB : data width of one lane
//   N   : number of lanes (N >= 2)
//   SW  : lane index width, derived from N (minimum 1)
//
// Ports
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   in_valid  : data_in carries a valid N-lane word
//   in_ready  : word can be accepted this cycle
//   data_in   : packed lanes, lane k at [k*MSB +: MSB]
//   out_valid : data_out carries a valid sample
//   out_ready : downstream accepts data_out this cycle
//   data_out  : current lane sample (0 while out_valid is low)
//   sel       : index of the lane on data_out
//   last      : high while data_out is lane N-1
module mux_serializer #(
    parameter int MSB = 16,
    parameter int N   = 2,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*MSB-1:0]   data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MSB-1:0]     data_out,
    output logic [SW-1:0]      sel,
    output logic               last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [SW-1:0] LAST_SEL = SW'(N - 1);

    state_t             state;
    state_t             state_next;
    logic [N*MSB-1:0]   hold;
    logic [N*MSB-1:0]   hold_next;
    logic [SW-1:0]      sel_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= '0;
            sel   <= '0;
        end else begin
            state <= state_next;
            hold  <= hold_next;
            sel   <= sel_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold;
        sel_next   = sel;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_next  = data_in;
                    sel_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                last      = (sel == LAST_SEL);
                // A new word may only enter as the final lane is taken.
                in_ready  = last & out_ready;
                if (out_ready) begin
                    if (!last) begin
                        sel_next = sel + 1'b1;
                    end else begin
                        // Explicit wrap so non-power-of-two N never overflows into unused codes.
                        sel_next = '0;
                        if (in_valid) begin
                            hold_next = data_in;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Lane select only looks at lanes 0..N-1; any other sel value yields 0.
    always_comb begin
        data_out = '0;
        if (state == SEND) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (sel == SW'(i)) begin
                    data_out = hold[i*MSB +: MSB];
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
module tb_mux_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=2, MSB=8 instance
    logic        rst2 = 1'b1;
    logic        iv2 = 1'b0;
    logic        ir2;
    logic [15:0] din2 = '0;
    logic        ov2;
    logic        ordy2 = 1'b0;
    logic [7:0]  dout2;
    logic [0:0]  sel2;
    logic        last2;

    // N=4, MSB=8 instance
    logic        rst4 = 1'b1;
    logic        iv4 = 1'b0;
    logic        ir4;
    logic [31:0] din4 = '0;
    logic        ov4;
    logic        ordy4 = 1'b0;
    logic [7:0]  dout4;
    logic [1:0]  sel4;
    logic        last4;

    mux_serializer #(.MSB(8), .N(2)) u2 (
        .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .data_in(din2),
        .out_valid(ov2), .out_ready(ordy2), .data_out(dout2), .sel(sel2), .last(last2)
    );

    mux_serializer #(.MSB(8), .N(4)) u4 (
        .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .data_in(din4),
        .out_valid(ov4), .out_ready(ordy4), .data_out(dout4), .sel(sel4), .last(last4)
    );

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        ordy;
        logic        ov;
        logic        ir;
        logic [7:0]  dout;
        logic        sel;
        logic        last;
    } vec_t;

    vec_t tbl[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] lanes_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] lanes_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic [15:0] din, input logic ordy,
                       input logic ov, input logic ir, input logic [7:0] dout,
                       input logic s, input logic l);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.dout = dout; v.sel = s; v.last = l;
        tbl.push_back(v);
    endtask

    task automatic drive4(input logic r, input logic iv, input logic [31:0] din, input logic ordy);
        @(negedge clk);
        rst4 = r; iv4 = iv; din4 = din; ordy4 = ordy;
        #1;
    endtask

    task automatic chk4(input string name, input logic ov, input logic ir,
                        input logic [7:0] d, input logic [1:0] s, input logic l);
        chk({name, ".out_valid"}, 32'(ov4), 32'(ov));
        chk({name, ".in_ready"}, 32'(ir4), 32'(ir));
        chk({name, ".data_out"}, 32'(dout4), 32'(d));
        chk({name, ".sel"}, 32'(sel4), 32'(s));
        chk({name, ".last"}, 32'(last4), 32'(l));
    endtask

    initial begin
        // Each row is one cycle: inputs driven, then outputs of the current state checked.
        //   iv  din       ordy | ov ir dout  sel last
        for (int i = 0; i < 10; i++)
            add(0, 16'h0000, i[0], 0, 1, 8'h00, 0, 0);       // idle after reset
        add(1, 16'h54AB, 1,   0, 1, 8'h00, 0, 0);            // basic: load
        add(0, 16'h0000, 1,   1, 0, 8'hAB, 0, 0);
        add(0, 16'h0000, 1,   1, 1, 8'h54, 1, 1);
        add(0, 16'h0000, 0,   0, 1, 8'h00, 0, 0);
        add(1, 16'h54AB, 0,   0, 1, 8'h00, 0, 0);            // backpressure: load
        for (int i = 0; i < 5; i++)
            add(0, 16'h0000, 0, 1, 0, 8'hAB, 0, 0);
        add(0, 16'h0000, 1,   1, 0, 8'hAB, 0, 0);
        add(0, 16'h0000, 1,   1, 1, 8'h54, 1, 1);
        add(1, 16'h54AB, 1,   0, 1, 8'h00, 0, 0);            // back-to-back
        add(1, 16'h1234, 1,   1, 0, 8'hAB, 0, 0);
        add(1, 16'h1234, 1,   1, 1, 8'h54, 1, 1);
        add(1, 16'h1234, 1,   1, 0, 8'h34, 0, 0);
        add(0, 16'h0000, 1,   1, 1, 8'h12, 1, 1);
        add(0, 16'h0000, 0,   0, 1, 8'h00, 0, 0);
        add(1, 16'hCAFE, 0,   0, 1, 8'h00, 0, 0);            // busy: data_in ignored
        add(1, 16'h9999, 1,   1, 0, 8'hFE, 0, 0);
        add(1, 16'h7777, 0,   1, 0, 8'hCA, 1, 1);
        add(0, 16'h5555, 0,   1, 0, 8'hCA, 1, 1);
        add(0, 16'h5555, 1,   1, 1, 8'hCA, 1, 1);
        add(0, 16'h0000, 1,   0, 1, 8'h00, 0, 0);

        // Reset both instances for two cycles.
        @(negedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        rst4 = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            iv2 = tbl[i].iv; din2 = tbl[i].din; ordy2 = tbl[i].ordy;
            #1;
            chk($sformatf("n2[%0d].out_valid", i), 32'(ov2), 32'(tbl[i].ov));
            chk($sformatf("n2[%0d].in_ready", i), 32'(ir2), 32'(tbl[i].ir));
            chk($sformatf("n2[%0d].data_out", i), 32'(dout2), 32'(tbl[i].dout));
            chk($sformatf("n2[%0d].sel", i), 32'(sel2), 32'(tbl[i].sel));
            chk($sformatf("n2[%0d].last", i), 32'(last2), 32'(tbl[i].last));
        end

        // N=4: full word, wrap, and back-to-back reload on the final lane.
        drive4(0, 1, 32'h44332211, 1);
        chk4("n4.load", 0, 1, 8'h00, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            drive4(0, (k == 3), 32'hDDCCBBAA, 1);
            chk4($sformatf("n4.a%0d", k), 1, (k == 3), lanes_a[k], 2'(k), (k == 3));
        end
        for (int k = 0; k < 4; k++) begin
            drive4(0, 0, 32'h00000000, 1);
            chk4($sformatf("n4.b%0d", k), 1, (k == 3), lanes_b[k], 2'(k), (k == 3));
        end
        drive4(0, 0, 32'h00000000, 0);
        chk4("n4.idle", 0, 1, 8'h00, 2'd0, 0);

        // N=4: reset after lane 0x22 has gone out.
        drive4(0, 1, 32'h44332211, 1);
        chk4("n4.rload", 0, 1, 8'h00, 2'd0, 0);
        drive4(0, 0, 32'h00000000, 1);
        chk4("n4.r0", 1, 0, 8'h11, 2'd0, 0);
        drive4(0, 0, 32'h00000000, 1);
        chk4("n4.r1", 1, 0, 8'h22, 2'd1, 0);
        drive4(1, 0, 32'h00000000, 0);
        chk4("n4.rpre", 1, 0, 8'h33, 2'd2, 0);
        for (int k = 0; k < 4; k++) begin
            drive4(0, 0, 32'h00000000, 1);
            chk4($sformatf("n4.rpost%0d", k), 0, 1, 8'h00, 2'd0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
